reg_file_2r1w: RTL and testbench



---
 rtl/reg_file_2r1w.sv | 112 +++++++++++
 tb/tb_reg_file_2r1w.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: NUM_REGS x DATA_W register file with one general write port,
// a dedicated PC update port and two registered read ports.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports; otherwise reads are read-before-write.
module reg_file_2r1w #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned PC_IDX   = NUM_REGS - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_wr_en,
  input  logic [DATA_W-1:0] pc_next,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  output logic [DATA_W-1:0] pc_out
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_sel_a_c;
  logic [DATA_W-1:0] rd_sel_b_c;

  // Register storage; the general write is applied last so it overrides pc_next on a PC conflict
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (pc_wr_en) begin
        regs[PC_ADDR] <= pc_next;
      end
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Port A operand select with write forwarding (general write beats PC advance)
  always_comb begin
    rd_sel_a_c = regs[rd_addr_a];
    if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_sel_a_c = wr_data;
    end else if (pc_wr_en && (rd_addr_a == PC_ADDR)) begin
      rd_sel_a_c = pc_next;
    end
  end

  // Port B operand select with write forwarding (general write beats PC advance)
  always_comb begin
    rd_sel_b_c = regs[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_sel_b_c = wr_data;
    end else if (pc_wr_en && (rd_addr_b == PC_ADDR)) begin
      rd_sel_b_c = pc_next;
    end
  end
`else
  // Port A operand select from pre-edge storage
  always_comb begin
    rd_sel_a_c = regs[rd_addr_a];
  end

  // Port B operand select from pre-edge storage
  always_comb begin
    rd_sel_b_c = regs[rd_addr_b];
  end
`endif

  // Port A output register: data holds when idle, valid is a per-request strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
    end else begin
      rd_valid_a <= rd_en_a;
      if (rd_en_a) begin
        rd_data_a <= rd_sel_a_c;
      end
    end
  end

  // Port B output register: data holds when idle, valid is a per-request strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_b <= rd_en_b;
      if (rd_en_b) begin
        rd_data_b <= rd_sel_b_c;
      end
    end
  end

  // Stored PC straight from storage, independent of forwarding
  assign pc_out = regs[PC_ADDR];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: directed scenarios plus randomized traffic checked
// against an array-based reference model. Honours REGFILE_BYPASS_EN.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_wr_en;
  logic [31:0] pc_next;
  logic        rd_en_a, rd_en_b;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic [31:0] pc_out;

  // wide instance for the parameter sweep
  logic        w2_en;
  logic [4:0]  w2_addr;
  logic [63:0] w2_data;
  logic        p2_en;
  logic [63:0] p2_next;
  logic        r2_en_a, r2_en_b;
  logic [4:0]  r2_addr_a, r2_addr_b;
  logic [63:0] r2_data_a, r2_data_b;
  logic        r2_valid_a, r2_valid_b;
  logic [63:0] pc2_out;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_regs [16];
  logic [31:0] exp_a, exp_b;
  logic        exp_va, exp_vb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file_2r1w dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr_en(pc_wr_en), .pc_next(pc_next),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .pc_out(pc_out)
  );

  reg_file_2r1w #(.DATA_W(64), .NUM_REGS(32)) dut2 (
    .clk(clk), .reset(reset),
    .wr_en(w2_en), .wr_addr(w2_addr), .wr_data(w2_data),
    .pc_wr_en(p2_en), .pc_next(p2_next),
    .rd_en_a(r2_en_a), .rd_addr_a(r2_addr_a),
    .rd_en_b(r2_en_b), .rd_addr_b(r2_addr_b),
    .rd_data_a(r2_data_a), .rd_valid_a(r2_valid_a),
    .rd_data_b(r2_data_b), .rd_valid_b(r2_valid_b),
    .pc_out(pc2_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // value a read of index a should capture this cycle, from the architectural rules
  function automatic logic [31:0] model_read(input logic [3:0] a);
    if (BYPASS && wr_en && wr_addr == a) return wr_data;
    if (BYPASS && pc_wr_en && a == 4'd15) return pc_next;
    return m_regs[a];
  endfunction

  task automatic set_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pc_wr_en = 1'b0; pc_next = '0;
    rd_en_a = 1'b0; rd_addr_a = '0;
    rd_en_b = 1'b0; rd_addr_b = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
  endtask

  // one clock with the currently driven inputs, then check every output
  task automatic step(input string tag);
    logic [31:0] na, nb;
    na = model_read(rd_addr_a);
    nb = model_read(rd_addr_b);
    @(posedge clk);
    exp_va = rd_en_a;
    exp_vb = rd_en_b;
    if (rd_en_a) exp_a = na;
    if (rd_en_b) exp_b = nb;
    if (pc_wr_en) m_regs[15] = pc_next;
    if (wr_en) m_regs[wr_addr] = wr_data;
    #1;
    chk({tag, ".valid_a"}, 64'(rd_valid_a), 64'(exp_va));
    chk({tag, ".valid_b"}, 64'(rd_valid_b), 64'(exp_vb));
    chk({tag, ".data_a"}, 64'(rd_data_a), 64'(exp_a));
    chk({tag, ".data_b"}, 64'(rd_data_b), 64'(exp_b));
    chk({tag, ".pc_out"}, 64'(pc_out), 64'(m_regs[15]));
  endtask

  initial begin
    set_idle();
    w2_en = 1'b0; w2_addr = '0; w2_data = '0; p2_en = 1'b0; p2_next = '0;
    r2_en_a = 1'b0; r2_addr_a = '0; r2_en_b = 1'b0; r2_addr_b = '0;
    model_clear();

    // reset state
    reset = 1'b1;
    #12;
    chk("rst.valid_a", 64'(rd_valid_a), 64'd0);
    chk("rst.valid_b", 64'(rd_valid_b), 64'd0);
    chk("rst.data_a", 64'(rd_data_a), 64'd0);
    chk("rst.data_b", 64'(rd_data_b), 64'd0);
    chk("rst.pc_out", 64'(pc_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // read every index after reset, one request per cycle
    for (int i = 0; i < 16; i++) begin
      rd_en_a = 1'b1; rd_addr_a = 4'(i);
      step("rst_read");
      chk("rst_read.zero", 64'(rd_data_a), 64'd0);
    end
    set_idle();
    step("rst_read_idle");

    // single request gives a single valid cycle
    rd_en_b = 1'b1; rd_addr_b = 4'd3;
    step("single_req");
    set_idle();
    step("single_req_drop");
    chk("single_req.valid_b_low", 64'(rd_valid_b), 64'd0);

    // dual port write/readback
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hAAAAAAAA;
    step("wr_r0");
    wr_addr = 4'd1; wr_data = 32'hCCCCCCCC;
    step("wr_r1");
    set_idle();
    rd_en_a = 1'b1; rd_addr_a = 4'd0;
    rd_en_b = 1'b1; rd_addr_b = 4'd1;
    step("dual_rd");
    chk("dual_rd.r0", 64'(rd_data_a), 64'hAAAAAAAA);
    chk("dual_rd.r1", 64'(rd_data_b), 64'hCCCCCCCC);

    // both ports on the same index
    rd_addr_b = 4'd0;
    step("same_idx");
    chk("same_idx.b", 64'(rd_data_b), 64'hAAAAAAAA);
    set_idle();

    // PC conflict: general write wins
    pc_wr_en = 1'b1; pc_next = 32'h00000104;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h00002000;
    step("pc_conflict");
    chk("pc_conflict.pc", 64'(pc_out), 64'h00002000);
    set_idle();

    // plain PC advance, readable through port B
    pc_wr_en = 1'b1; pc_next = 32'h00002004;
    step("pc_adv");
    set_idle();
    rd_en_b = 1'b1; rd_addr_b = 4'd15;
    step("pc_read");
    chk("pc_read.data", 64'(rd_data_b), 64'h00002004);
    set_idle();

    // same-cycle write/read of R4
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h11111111;
    step("r4_init");
    wr_data = 32'h22222222;
    rd_en_a = 1'b1; rd_addr_a = 4'd4;
    step("r4_wr_rd");
    chk("r4_wr_rd.const", 64'(rd_data_a), BYPASS ? 64'h22222222 : 64'h11111111);
    set_idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = $urandom;
      pc_wr_en  = ($urandom_range(0, 2) == 0);
      pc_next   = $urandom;
      rd_en_a   = ($urandom_range(0, 3) != 0);
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_en_b   = ($urandom_range(0, 3) != 0);
      rd_addr_b = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      step("rand");
    end
    set_idle();

    // async reset in the middle of a read stream
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hAAAAAAAA;
    pc_wr_en = 1'b1; pc_next = 32'h00000040;
    step("stream_setup");
    set_idle();
    rd_en_a = 1'b1; rd_addr_a = 4'd0;
    for (int i = 0; i < 3; i++) step("stream");
    chk("stream.data", 64'(rd_data_a), 64'hAAAAAAAA);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.valid_a", 64'(rd_valid_a), 64'd0);
    chk("async_rst.data_a", 64'(rd_data_a), 64'd0);
    chk("async_rst.pc_out", 64'(pc_out), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    chk("in_rst.valid_a", 64'(rd_valid_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst");
    chk("post_rst.valid_a", 64'(rd_valid_a), 64'd1);
    chk("post_rst.r0", 64'(rd_data_a), 64'd0);
    set_idle();

    // wide configuration: PC is R31
    p2_en = 1'b1; p2_next = 64'hDEADBEEF_00000008;
    @(posedge clk);
    #1;
    p2_en = 1'b0;
    chk("wide.pc_out", pc2_out, 64'hDEADBEEF_00000008);
    r2_en_a = 1'b1; r2_addr_a = 5'd31;
    @(posedge clk);
    #1;
    r2_en_a = 1'b0;
    chk("wide.valid_a", 64'(r2_valid_a), 64'd1);
    chk("wide.r31", r2_data_a, 64'hDEADBEEF_00000008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
